// File: rtl/ddr_init_seq.sv
// DDR bring-up sequencer: PLL reset and lock qualification, reset release, controller config, then ready/error.
// Optional build macro DDR_INIT_RETRY_EN: a wait-state timeout restarts from PLL_RST up to 3 times before ERR.
module ddr_init_seq #(
    parameter int unsigned PLL_RST_CYCLES     = 1000,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned TIMEOUT_CYCLES     = 1000000
) (
    input  logic       clk_100,
    input  logic       rstn,
    input  logic       start,
    input  logic       ddr_pll_lock,
    input  logic       cfg_done,
    output logic       ddr_pll_rstn,
    output logic       phy_rstn,
    output logic       ctrl_rstn,
    output logic       cfg_reset,
    output logic       cfg_sel,
    output logic       cfg_start,
    output logic       axi0_ARESETn,
    output logic       regARESETn,
    output logic       init_done,
    output logic       init_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLL_RST  = 3'd1,
        S_PLL_WAIT = 3'd2,
        S_RST_REL  = 3'd3,
        S_CFG_RUN  = 3'd4,
        S_CFG_WAIT = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_e;

    typedef struct packed {
        logic ddr_pll_rstn;
        logic phy_rstn;
        logic ctrl_rstn;
        logic cfg_reset;
        logic cfg_sel;
        logic cfg_start;
        logic axi_rstn;
        logic reg_rstn;
        logic init_done;
        logic init_err;
    } outs_t;

    localparam outs_t OUTS_RST = '{ddr_pll_rstn: 1'b0, phy_rstn: 1'b0, ctrl_rstn: 1'b0,
                                   cfg_reset: 1'b1, cfg_sel: 1'b0, cfg_start: 1'b0,
                                   axi_rstn: 1'b0, reg_rstn: 1'b0, init_done: 1'b0,
                                   init_err: 1'b0};

    localparam int PLL_W    = $clog2(PLL_RST_CYCLES + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PLL_W-1:0]    PLL_MAX     = PLL_W'(PLL_RST_CYCLES);
    localparam logic [PLL_W-1:0]    PLL_LAST    = PLL_W'(PLL_RST_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    outs_t               outs_q, outs_d;
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                lock_meta_q, lock_sync_q;
    logic                done_meta_q, done_sync_q;
    logic [PLL_W-1:0]    pll_cnt_q, pll_cnt_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                rst_ok;
    logic                tmo_hit;
    logic                restart;
    state_e              fail_state;

    assign rst_ok  = rst_sync_q[1];
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    assign restart = start && rst_ok;

`ifdef DDR_INIT_RETRY_EN
    localparam logic [1:0] RETRY_MAX = 2'd3;
    logic [1:0] retry_q, retry_d;

    assign fail_state = (retry_q == RETRY_MAX) ? S_ERR : S_PLL_RST;

    always_comb begin
        retry_d = retry_q;
        if ((state_q == S_IDLE || state_q == S_ERR) && state_d == S_PLL_RST) begin
            retry_d = '0;
        end else if (state_d == S_DONE) begin
            retry_d = '0;
        end else if ((state_q == S_PLL_WAIT || state_q == S_CFG_WAIT) && state_d == S_PLL_RST
                     && retry_q != RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
        end
    end

    always_ff @(posedge clk_100 or negedge rstn) begin
        if (!rstn) retry_q <= '0;
        else       retry_q <= retry_d;
    end
`else
    assign fail_state = S_ERR;
`endif

    // State register; the lock/cfg_done synchronizers and the reset-release stretcher live here too.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_100 or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            rst_sync_q  <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_sync_q  <= rst_sync_d;
            lock_meta_q <= ddr_pll_lock;
            lock_sync_q <= lock_meta_q;
            done_meta_q <= cfg_done;
            done_sync_q <= done_meta_q;
        end
    end

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (restart) state_d = S_PLL_RST;
            S_PLL_RST:  if (pll_cnt_q == PLL_LAST) state_d = S_PLL_WAIT;
            S_PLL_WAIT: begin
                if (lock_sync_q && stable_cnt_q == STABLE_LAST) state_d = S_RST_REL;
                else if (tmo_hit)                                state_d = fail_state;
            end
            S_RST_REL:  state_d = S_CFG_RUN;
            S_CFG_RUN:  state_d = S_CFG_WAIT;
            S_CFG_WAIT: begin
                if (done_sync_q)  state_d = S_DONE;
                else if (tmo_hit) state_d = fail_state;
            end
            S_DONE:     if (!lock_sync_q) state_d = S_ERR;
            S_ERR:      if (restart) state_d = S_PLL_RST;
            default:    state_d = S_IDLE;
        endcase
    end

    // Counters run only while the state holds, so each one restarts from zero on state entry.
    always_comb begin
        pll_cnt_d    = '0;
        stable_cnt_d = '0;
        tmo_cnt_d    = '0;
        if (state_q == S_PLL_RST && state_d == S_PLL_RST) begin
            pll_cnt_d = (pll_cnt_q == PLL_MAX) ? pll_cnt_q : pll_cnt_q + PLL_W'(1);
        end
        if (state_q == S_PLL_WAIT && state_d == S_PLL_WAIT && lock_sync_q) begin
            stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? stable_cnt_q
                                                        : stable_cnt_q + STABLE_W'(1);
        end
        if ((state_q == S_PLL_WAIT || state_q == S_CFG_WAIT) && state_d == state_q) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_100 or negedge rstn) begin
        if (!rstn) begin
            pll_cnt_q    <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            pll_cnt_q    <= pll_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Outputs decode the next state and are registered, so they change on the same edge as seq_state.
    always_comb begin
        outs_d = OUTS_RST;
        case (state_d)
            S_PLL_WAIT: outs_d.ddr_pll_rstn = 1'b1;
            S_RST_REL, S_CFG_RUN, S_CFG_WAIT, S_DONE: begin
                outs_d.ddr_pll_rstn = 1'b1;
                outs_d.phy_rstn     = 1'b1;
                outs_d.ctrl_rstn    = 1'b1;
                outs_d.cfg_reset    = 1'b0;
                outs_d.reg_rstn     = 1'b1;
                outs_d.cfg_start    = (state_d == S_CFG_RUN);
                outs_d.axi_rstn     = (state_d == S_DONE);
                outs_d.init_done    = (state_d == S_DONE);
            end
            S_ERR:      outs_d.init_err = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rstn) begin
        if (!rstn) outs_q <= OUTS_RST;
        else       outs_q <= outs_d;
    end

    assign ddr_pll_rstn = outs_q.ddr_pll_rstn;
    assign phy_rstn     = outs_q.phy_rstn;
    assign ctrl_rstn    = outs_q.ctrl_rstn;
    assign cfg_reset    = outs_q.cfg_reset;
    assign cfg_sel      = outs_q.cfg_sel;
    assign cfg_start    = outs_q.cfg_start;
    assign axi0_ARESETn = outs_q.axi_rstn;
    assign regARESETn   = outs_q.reg_rstn;
    assign init_done    = outs_q.init_done;
    assign init_err     = outs_q.init_err;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: nominal bring-up, lock glitch, lock loss, config timeout,
// mid-sequence reset, reset-release synchronization and lock-never-asserts timeout.
module tb_ddr_init_seq;

    logic       clk_100 = 1'b0;
    logic       rstn, start, ddr_pll_lock, cfg_done;
    logic       ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_reset, cfg_sel, cfg_start;
    logic       axi0_ARESETn, regARESETn, init_done, init_err;
    logic [2:0] seq_state;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DDR_INIT_RETRY_EN
    localparam int EXP_ENTRIES = 4;
`else
    localparam int EXP_ENTRIES = 1;
`endif

    always #5 clk_100 = ~clk_100;

    ddr_init_seq #(
        .PLL_RST_CYCLES    (10),
        .LOCK_STABLE_CYCLES(4),
        .TIMEOUT_CYCLES    (50)
    ) dut (
        .clk_100     (clk_100),
        .rstn        (rstn),
        .start       (start),
        .ddr_pll_lock(ddr_pll_lock),
        .cfg_done    (cfg_done),
        .ddr_pll_rstn(ddr_pll_rstn),
        .phy_rstn    (phy_rstn),
        .ctrl_rstn   (ctrl_rstn),
        .cfg_reset   (cfg_reset),
        .cfg_sel     (cfg_sel),
        .cfg_start   (cfg_start),
        .axi0_ARESETn(axi0_ARESETn),
        .regARESETn  (regARESETn),
        .init_done   (init_done),
        .init_err    (init_err),
        .seq_state   (seq_state)
    );

    // {ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_reset, cfg_sel, cfg_start,
    //  axi0_ARESETn, regARESETn, init_done, init_err, seq_state[2:0]}
    function automatic logic [12:0] exp_vec(input logic [2:0] st);
        case (st)
            3'd0:    return 13'b0001_0000_00_000;
            3'd1:    return 13'b0001_0000_00_001;
            3'd2:    return 13'b1001_0000_00_010;
            3'd3:    return 13'b1110_0001_00_011;
            3'd4:    return 13'b1110_0101_00_100;
            3'd5:    return 13'b1110_0001_00_101;
            3'd6:    return 13'b1110_0011_10_110;
            default: return 13'b0001_0000_01_111;
        endcase
    endfunction

    function automatic logic [12:0] out_vec();
        return {ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_reset, cfg_sel, cfg_start,
                axi0_ARESETn, regARESETn, init_done, init_err, seq_state};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_100);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int cyc = 0;
        while (seq_state !== st && cyc < budget) begin
            step();
            cyc++;
        end
        check(tag, {29'd0, seq_state}, {29'd0, st});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int entries;
        logic [2:0] prev;

        rstn = 1'b0; start = 1'b0; ddr_pll_lock = 1'b0; cfg_done = 1'b0;
        repeat (3) step();
        check("reset_outputs", out_vec(), exp_vec(3'd0));
        rstn = 1'b1;
        repeat (4) step();
        check("idle_hold", out_vec(), exp_vec(3'd0));

        // Nominal bring-up
        start = 1'b1;
        step();
        check("pll_rst_entry", out_vec(), exp_vec(3'd1));
        start = 1'b0;
        cnt = 0;
        while (seq_state == 3'd1 && cnt < 30) begin
            cnt++;
            step();
        end
        check("pll_rst_len", cnt, 10);
        check("pll_wait_entry", out_vec(), exp_vec(3'd2));
        ddr_pll_lock = 1'b1;
        repeat (5) step();
        check("lock_qualifying", {29'd0, seq_state}, 32'd2);
        step();
        check("rst_rel", out_vec(), exp_vec(3'd3));
        step();
        check("cfg_run", out_vec(), exp_vec(3'd4));
        step();
        check("cfg_wait", out_vec(), exp_vec(3'd5));
        repeat (19) step();
        cfg_done = 1'b1;
        repeat (2) step();
        check("cfg_done_sync", {29'd0, seq_state}, 32'd5);
        step();
        check("done", out_vec(), exp_vec(3'd6));
        cfg_done = 1'b0;

        // Lock loss while DONE
        repeat (3) step();
        ddr_pll_lock = 1'b0;
        repeat (2) step();
        check("lock_loss_sync", out_vec(), exp_vec(3'd6));
        step();
        check("lock_loss_err", out_vec(), exp_vec(3'd7));
        repeat (3) step();
        check("err_hold", out_vec(), exp_vec(3'd7));

        // Config timeout
        start = 1'b1;
        ddr_pll_lock = 1'b1;
        step();
        check("err_restart", out_vec(), exp_vec(3'd1));
        start = 1'b0;
        wait_state("reach_cfg_wait", 3'd5, 60);
        cnt = 0;
        while (seq_state == 3'd5 && cnt < 100) begin
            cnt++;
            step();
        end
        check("cfg_timeout_len", cnt, 50);
        check("cfg_timeout_err", out_vec(), exp_vec(3'd7));

        // Lock glitch: 3 high, 1 low, then high
        start = 1'b1;
        ddr_pll_lock = 1'b0;
        step();
        check("timeout_restart", {29'd0, seq_state}, 32'd1);
        start = 1'b0;
        wait_state("glitch_pll_wait", 3'd2, 30);
        ddr_pll_lock = 1'b1;
        repeat (3) step();
        ddr_pll_lock = 1'b0;
        step();
        ddr_pll_lock = 1'b1;
        repeat (5) step();
        check("glitch_no_early", {29'd0, seq_state}, 32'd2);
        step();
        check("glitch_rst_rel", {29'd0, seq_state}, 32'd3);

        // Reset pulse during CFG_WAIT
        wait_state("reach_cfg_wait2", 3'd5, 10);
        step();
        rstn = 1'b0;
        #1;
        check("async_reset", out_vec(), exp_vec(3'd0));
        step();
        rstn = 1'b1;
        cfg_done = 1'b1;
        repeat (6) step();
        check("no_restart", out_vec(), exp_vec(3'd0));

        // Start held through reset release: FSM waits for the synchronized release
        rstn = 1'b0;
        ddr_pll_lock = 1'b0;
        cfg_done = 1'b0;
        step();
        start = 1'b1;
        rstn = 1'b1;
        step();
        check("rst_sync_1", {29'd0, seq_state}, 32'd0);
        step();
        check("rst_sync_2", {29'd0, seq_state}, 32'd0);
        step();
        check("rst_sync_start", {29'd0, seq_state}, 32'd1);
        start = 1'b0;

        // Lock never asserts
        entries = 1;
        prev = seq_state;
        cnt = 0;
        while (seq_state !== 3'd7 && cnt < 500) begin
            step();
            cnt++;
            if (seq_state == 3'd1 && prev != 3'd1) entries++;
            prev = seq_state;
        end
        check("pll_rst_entries", entries, EXP_ENTRIES);
        check("lock_timeout_err", out_vec(), exp_vec(3'd7));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
